int_sched: RTL and testbench
============================

// Module: int_sched
// PURPOSE
//  Interrupt scheduler beside the CSR unit. Captures interrupt sources into a registered MIP image and masks them
//  with MIE and MSTATUS.MIE. Arbitrates by fixed priority and presents one frozen request plus cause to the MA stage
//  under a req/ack handshake, then blocks re-entry until MRET. Also keeps a saturating count of correctable load errors.
// PARAMETERS
//  CNT_W      8   width of correctable-load-error counter
//  LCER_THR   16  counter value at which s_lcer_thr_o asserts (must be < 2**CNT_W)
// PORTS
//  s_clk_i          in   1      clock
//  s_rst_i          in   1      reset, synchronous, active-high
//  s_int_meip_i     in   1      external interrupt, level
//  s_int_mtip_i     in   1      timer interrupt, level
//  s_int_msip_i     in   1      software interrupt, level
//  s_int_uce_i      in   1      regfile uncorrectable error, 1-cycle pulse
//  s_int_lcer_i     in   1      correctable load error, 1-cycle pulse
//  s_mie_i          in   15     MIE CSR value
//  s_gie_i          in   1      MSTATUS.MIE
//  s_mip_clr_i      in   15     per-bit clear of sticky MIP bits (CSR write of 0); valid on bits 14,13 only
//  s_cnt_clr_i      in   1      clear LCER counter
//  s_stall_i        in   1      MA stall
//  s_flush_i        in   1      MA flush
//  s_ack_i          in   1      pipeline accepted the interrupt (interrupted)
//  s_mret_i         in   1      MRET retired
//  s_int_req_o      out  1      interrupt request to MA
//  s_int_cause_o    out  32     MCAUSE value for request: {1'b1,27'b0,code[3:0]}
//  s_mip_o          out  15     registered MIP image
//  s_in_handler_o   out  1      trap handler active
//  s_lcer_cnt_o     out  CNT_W  correctable load error count
//  s_lcer_thr_o     out  1      s_lcer_cnt_o >= LCER_THR
// BEHAVIOUR
//  Reset: all outputs 0; cause 0; FSM IDLE; counter 0; sticky bits cleared. Reset at any state wins over everything.
//  MIP bits: 3=MSI, 7=MTI, 11=MEI mirror levels with 1-cycle latency; 13=LCER, 14=UCE sticky.
//   Sticky set by pulse (visible next cycle).
//   Sticky cleared by s_mip_clr_i bit, or by s_ack_i while frozen code equals that bit.
//   Set and clear in the same cycle: set wins. Other MIP bits always 0.
//  Eligible = s_mip_o & s_mie_i & {15{s_gie_i}}. Exception: UCE (bit 14) ignores s_gie_i; it is still gated by MIE[14].
//  Priority, high to low: UCE(14) > MEI(11) > MSI(3) > MTI(7) > LCER(13).
//  FSM IDLE:
//   eligible!=0 & ~s_stall_i & ~s_flush_i -> REQ.
//   On entry, latch the winning code; s_int_req_o=1 from the next cycle.
//   Latency: source pulse at t -> MIP at t+1 -> req at t+2.
//  FSM REQ:
//   Cause frozen; a higher-priority arrival does not preempt. req stays high through stalls.
//   s_ack_i -> HANDLER, req=0 next cycle.
//   s_flush_i without ack -> IDLE, req=0 next cycle; re-arbitrate the following cycle.
//   Frozen code no longer eligible (source dropped or masked) & no ack -> IDLE.
//   ack and flush together: ack wins.
//  FSM HANDLER:
//   s_in_handler_o=1; no requests issued.
//   s_mret_i -> IDLE; a pending eligible source may request 2 cycles after MRET.
//   s_ack_i in IDLE/HANDLER is ignored; s_mret_i outside HANDLER is ignored.
//  LCER counter:
//   +1 per s_int_lcer_i pulse; saturates at 2**CNT_W-1 (no wrap).
//   s_cnt_clr_i has priority over increment in the same cycle.
//   s_lcer_thr_o is registered from the count.
// STRUCTURE
//  p_hardisc holds the following constants: MIP bit indices (MSI=3, MTI=7, MEI=11, LCER=13, UCE=14), cause codes,
//  and typedef enum logic[1:0] {IS_IDLE, IS_REQ, IS_HANDLER}.
//  Sub-module int_prio_enc: combinational 15-bit eligible vector -> {valid, code[3:0]} implementing the priority above.
//  The scheduler is instantiated once per replica in protected builds. Triplication and voting are done by the
//  instantiating unit.
// TESTING
//  1) mie=0x888, gie=1. Raise meip and mtip in the same cycle t -> req at t+2 with cause 0x8000000B.
//     Ack at t+4 -> handler=1. mret -> the MTI request (0x80000007) follows 2 cycles later.
//  2) uce pulse with gie=0, mie[14]=1 -> req with cause 0x8000000E. Ack clears MIP[14].
//     With mie[14]=0: no req, MIP[14] stays 1 until s_mip_clr_i[14].
//  3) In REQ with cause 7, hold stall 5 cycles, then raise meip -> cause stays 7 until ack.
//     A flush in REQ -> req=0, then the next request carries cause 0xB.
//  4) Drop mtip while REQ(7) with no ack -> IDLE, req=0, no handler entry.
//     Ack and flush in the same cycle -> HANDLER.
//  5) CNT_W=4: 20 lcer pulses -> count 15 (saturated), thr=1 at count 15.
//     s_cnt_clr_i together with a pulse -> count 0.
//  6) Assert s_rst_i in the cycle of ack while in REQ -> next cycle all outputs 0, FSM IDLE, sticky bits 0.

Source files
------------

// File: rtl/int_sched_pkg.sv
// Shared constants for the interrupt scheduler: MIP bit positions, cause codes and FSM states.
package p_hardisc;

  localparam int unsigned MIP_MSI  = 3;
  localparam int unsigned MIP_MTI  = 7;
  localparam int unsigned MIP_MEI  = 11;
  localparam int unsigned MIP_LCER = 13;
  localparam int unsigned MIP_UCE  = 14;

  // Cause codes equal the MIP bit index of their source.
  localparam logic [3:0] CODE_MSI  = 4'd3;
  localparam logic [3:0] CODE_MTI  = 4'd7;
  localparam logic [3:0] CODE_MEI  = 4'd11;
  localparam logic [3:0] CODE_LCER = 4'd13;
  localparam logic [3:0] CODE_UCE  = 4'd14;

  typedef enum logic [1:0] {
    IS_IDLE,
    IS_REQ,
    IS_HANDLER
  } is_state_t;

  function automatic logic [31:0] make_cause(input logic [3:0] code);
    return {1'b1, 27'b0, code};
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: UCE > MEI > MSI > MTI > LCER.
module int_prio_enc
  import p_hardisc::*;
(
  input  logic [14:0] elig,
  output logic        valid,
  output logic [3:0]  code
);

  logic unused_bits;
  assign unused_bits = ^{elig[12], elig[10:8], elig[6:4], elig[2:0]};

  always_comb begin
    valid = 1'b1;
    code  = '0;
    if (elig[MIP_UCE])       code = CODE_UCE;
    else if (elig[MIP_MEI])  code = CODE_MEI;
    else if (elig[MIP_MSI])  code = CODE_MSI;
    else if (elig[MIP_MTI])  code = CODE_MTI;
    else if (elig[MIP_LCER]) code = CODE_LCER;
    else                     valid = 1'b0;
  end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: registered MIP image, masking, fixed-priority arbitration,
// req/ack handshake to MA with re-entry blocked until MRET, and a saturating LCER counter.
module int_sched
  import p_hardisc::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LCER_THR = 16
) (
  input  logic             s_clk_i,
  input  logic             s_rst_i,
  input  logic             s_int_meip_i,
  input  logic             s_int_mtip_i,
  input  logic             s_int_msip_i,
  input  logic             s_int_uce_i,
  input  logic             s_int_lcer_i,
  input  logic [14:0]      s_mie_i,
  input  logic             s_gie_i,
  input  logic [14:0]      s_mip_clr_i,
  input  logic             s_cnt_clr_i,
  input  logic             s_stall_i,
  input  logic             s_flush_i,
  input  logic             s_ack_i,
  input  logic             s_mret_i,
  output logic             s_int_req_o,
  output logic [31:0]      s_int_cause_o,
  output logic [14:0]      s_mip_o,
  output logic             s_in_handler_o,
  output logic [CNT_W-1:0] s_lcer_cnt_o,
  output logic             s_lcer_thr_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR_V   = LCER_THR[CNT_W-1:0];

  is_state_t        state, state_d;
  logic [14:0]      mip_q, mip_d;
  logic [14:0]      elig;
  logic [31:0]      cause_q;
  logic [3:0]       frz_code;
  logic             frz_elig;
  logic             win_valid;
  logic [3:0]       win_code;
  logic             load;
  logic             ack_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             thr_q;

  logic unused_clr;
  assign unused_clr = ^s_mip_clr_i[12:0];

  assign frz_code = cause_q[3:0];
  assign ack_hit  = (state == IS_REQ) && s_ack_i;

  // Sticky bits: set wins over both CSR clear and ack-of-frozen-code clear.
  always_comb begin
    mip_d           = '0;
    mip_d[MIP_MSI]  = s_int_msip_i;
    mip_d[MIP_MTI]  = s_int_mtip_i;
    mip_d[MIP_MEI]  = s_int_meip_i;
    mip_d[MIP_LCER] = s_int_lcer_i | (mip_q[MIP_LCER] &
                      ~(s_mip_clr_i[MIP_LCER] | (ack_hit && frz_code == CODE_LCER)));
    mip_d[MIP_UCE]  = s_int_uce_i | (mip_q[MIP_UCE] &
                      ~(s_mip_clr_i[MIP_UCE] | (ack_hit && frz_code == CODE_UCE)));
  end

  // UCE bypasses the global enable but still honours its own MIE bit.
  always_comb begin
    elig          = mip_q & s_mie_i & {15{s_gie_i}};
    elig[MIP_UCE] = mip_q[MIP_UCE] & s_mie_i[MIP_UCE];
  end

  always_comb begin
    case (frz_code)
      CODE_UCE:  frz_elig = elig[MIP_UCE];
      CODE_MEI:  frz_elig = elig[MIP_MEI];
      CODE_MSI:  frz_elig = elig[MIP_MSI];
      CODE_MTI:  frz_elig = elig[MIP_MTI];
      CODE_LCER: frz_elig = elig[MIP_LCER];
      default:   frz_elig = 1'b0;
    endcase
  end

  int_prio_enc u_prio (
    .elig  (elig),
    .valid (win_valid),
    .code  (win_code)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IS_IDLE: begin
        if (win_valid && !s_stall_i && !s_flush_i) begin
          state_d = IS_REQ;
          load    = 1'b1;
        end
      end
      IS_REQ: begin
        if (s_ack_i)                     state_d = IS_HANDLER;
        else if (s_flush_i || !frz_elig) state_d = IS_IDLE;
      end
      IS_HANDLER: begin
        if (s_mret_i) state_d = IS_IDLE;
      end
      default: state_d = IS_IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state   <= IS_IDLE;
      cause_q <= '0;
      mip_q   <= '0;
    end else begin
      state <= state_d;
      mip_q <= mip_d;
      if (load) cause_q <= make_cause(win_code);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s_cnt_clr_i)                          cnt_d = '0;
    else if (s_int_lcer_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Threshold flag is computed from the next count so it stays aligned with the count output.
  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      cnt_q <= '0;
      thr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      thr_q <= (cnt_d >= THR_V);
    end
  end

  assign s_int_req_o    = (state == IS_REQ);
  assign s_in_handler_o = (state == IS_HANDLER);
  assign s_int_cause_o  = cause_q;
  assign s_mip_o        = mip_q;
  assign s_lcer_cnt_o   = cnt_q;
  assign s_lcer_thr_o   = thr_q;

endmodule

// File: tb/tb_int_sched.sv
// Directed bench for int_sched with hand-computed expectations (CNT_W=4, LCER_THR=15).
module tb_int_sched;

  logic        clk;
  logic        rst;
  logic        meip, mtip, msip, uce, lcer;
  logic [14:0] mie;
  logic        gie;
  logic [14:0] mip_clr;
  logic        cnt_clr, stall, flush, ack, mret;
  logic        req;
  logic [31:0] cause;
  logic [14:0] mip;
  logic        in_handler;
  logic [3:0]  cnt;
  logic        thr;

  int total = 0;
  int bad   = 0;

  int_sched #(.CNT_W(4), .LCER_THR(15)) dut (
    .s_clk_i        (clk),
    .s_rst_i        (rst),
    .s_int_meip_i   (meip),
    .s_int_mtip_i   (mtip),
    .s_int_msip_i   (msip),
    .s_int_uce_i    (uce),
    .s_int_lcer_i   (lcer),
    .s_mie_i        (mie),
    .s_gie_i        (gie),
    .s_mip_clr_i    (mip_clr),
    .s_cnt_clr_i    (cnt_clr),
    .s_stall_i      (stall),
    .s_flush_i      (flush),
    .s_ack_i        (ack),
    .s_mret_i       (mret),
    .s_int_req_o    (req),
    .s_int_cause_o  (cause),
    .s_mip_o        (mip),
    .s_in_handler_o (in_handler),
    .s_lcer_cnt_o   (cnt),
    .s_lcer_thr_o   (thr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; meip = 0; mtip = 0; msip = 0; uce = 0; lcer = 0;
    mie = '0; gie = 0; mip_clr = '0; cnt_clr = 0; stall = 0; flush = 0; ack = 0; mret = 0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_cause", cause, 32'd0);
    chk("rst_mip", 32'(mip), 32'd0);
    chk("rst_hdl", 32'(in_handler), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_thr", 32'(thr), 32'd0);

    // 1) MEI beats MTI; MTI follows two cycles after MRET
    mie = 15'h0888; gie = 1;
    meip = 1; mtip = 1;
    step();
    chk("t1_mip", 32'(mip), 32'h0880);
    chk("t1_req_t1", 32'(req), 32'd0);
    step();
    chk("t1_req_t2", 32'(req), 32'd1);
    chk("t1_cause_b", cause, 32'h8000000B);
    step();
    step();
    ack = 1;
    step();
    ack = 0; meip = 0;
    chk("t1_hdl", 32'(in_handler), 32'd1);
    chk("t1_req_hdl", 32'(req), 32'd0);
    step();
    chk("t1_hdl_hold", 32'(in_handler), 32'd1);
    chk("t1_noreq_hdl", 32'(req), 32'd0);
    mret = 1;
    step();
    mret = 0;
    chk("t1_hdl_exit", 32'(in_handler), 32'd0);
    chk("t1_req_m1", 32'(req), 32'd0);
    step();
    chk("t1_req_m2", 32'(req), 32'd1);
    chk("t1_cause_7", cause, 32'h80000007);

    // 3) Stall does not drop req; later MEI does not preempt; flush re-arbitrates
    stall = 1;
    repeat (5) step();
    chk("t3_req_stall", 32'(req), 32'd1);
    stall = 0; meip = 1;
    step();
    step();
    chk("t3_nopreempt", cause, 32'h80000007);
    chk("t3_req_held", 32'(req), 32'd1);
    flush = 1;
    step();
    flush = 0;
    chk("t3_flush_req", 32'(req), 32'd0);
    step();
    chk("t3_rearb_req", 32'(req), 32'd1);
    chk("t3_rearb_cause", cause, 32'h8000000B);

    // 4) Source drop in REQ returns to IDLE without handler
    ack = 1;
    step();
    ack = 0; meip = 0;
    chk("t4_hdl", 32'(in_handler), 32'd1);
    mret = 1;
    step();
    mret = 0;
    step();
    chk("t4_req7", cause, 32'h80000007);
    chk("t4_req7_v", 32'(req), 32'd1);
    mtip = 0;
    step();
    chk("t4_req_lag", 32'(req), 32'd1);
    step();
    chk("t4_drop_req", 32'(req), 32'd0);
    chk("t4_drop_hdl", 32'(in_handler), 32'd0);
    step();
    chk("t4_idle_req", 32'(req), 32'd0);
    mtip = 1;
    step();
    step();
    chk("t4_req_again", 32'(req), 32'd1);
    ack = 1; flush = 1;
    step();
    ack = 0; flush = 0;
    chk("t4_ackflush_hdl", 32'(in_handler), 32'd1);
    chk("t4_ackflush_req", 32'(req), 32'd0);
    mret = 1; mtip = 0;
    step();
    mret = 0;
    step();
    step();
    chk("t4_quiet", 32'(req), 32'd0);

    // 2) UCE ignores gie but honours mie[14]
    gie = 0; mie = 15'h4888;
    uce = 1;
    step();
    uce = 0;
    chk("t2_mip_uce", 32'(mip), 32'h4000);
    step();
    chk("t2_req_uce", 32'(req), 32'd1);
    chk("t2_cause_e", cause, 32'h8000000E);
    ack = 1;
    step();
    ack = 0;
    chk("t2_ack_clr", 32'(mip), 32'h0000);
    chk("t2_hdl", 32'(in_handler), 32'd1);
    mret = 1;
    step();
    mret = 0;
    mie = 15'h0888;
    uce = 1;
    step();
    uce = 0;
    step();
    step();
    chk("t2_masked_req", 32'(req), 32'd0);
    chk("t2_sticky", 32'(mip), 32'h4000);
    mip_clr = 15'h4000;
    step();
    mip_clr = '0;
    chk("t2_csr_clr", 32'(mip), 32'h0000);
    uce = 1;
    step();
    uce = 1; mip_clr = 15'h4000;
    step();
    uce = 0;
    chk("t2_set_wins", 32'(mip), 32'h4000);
    step();
    mip_clr = '0;
    chk("t2_clr_after", 32'(mip), 32'h0000);

    // 5) LCER counter saturates at 15, thr at 15; clear beats increment
    for (int i = 0; i < 14; i++) begin
      lcer = 1; step(); lcer = 0; step();
    end
    chk("t5_cnt14", 32'(cnt), 32'd14);
    chk("t5_thr14", 32'(thr), 32'd0);
    chk("t5_mip_lcer", 32'(mip), 32'h2000);
    lcer = 1; step(); lcer = 0; step();
    chk("t5_cnt15", 32'(cnt), 32'd15);
    chk("t5_thr15", 32'(thr), 32'd1);
    for (int i = 0; i < 5; i++) begin
      lcer = 1; step(); lcer = 0; step();
    end
    chk("t5_sat", 32'(cnt), 32'd15);
    chk("t5_req_none", 32'(req), 32'd0);
    cnt_clr = 1; lcer = 1;
    step();
    cnt_clr = 0; lcer = 0;
    chk("t5_clr_cnt", 32'(cnt), 32'd0);
    chk("t5_clr_thr", 32'(thr), 32'd0);
    mip_clr = 15'h2000;
    step();
    mip_clr = '0;
    chk("t5_mip_clr", 32'(mip), 32'h0000);

    // 6) Reset during ack in REQ wins over everything
    gie = 1;
    meip = 1; uce = 1; lcer = 1;
    step();
    uce = 0; lcer = 0;
    chk("t6_mip", 32'(mip), 32'h6800);
    step();
    chk("t6_cause_b", cause, 32'h8000000B);
    chk("t6_cnt1", 32'(cnt), 32'd1);
    ack = 1; rst = 1;
    step();
    ack = 0; rst = 0; meip = 0;
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_cause", cause, 32'd0);
    chk("t6_mip0", 32'(mip), 32'd0);
    chk("t6_hdl", 32'(in_handler), 32'd0);
    chk("t6_cnt", 32'(cnt), 32'd0);
    step();
    chk("t6_idle_req", 32'(req), 32'd0);
    chk("t6_idle_hdl", 32'(in_handler), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
